// File: rtl/turf_pkg.sv
// Shared definitions for the turf board: cell codes, address field widths,
// score width and the scorer FSM state encoding.
package turf_pkg;

  localparam int X_BITS     = 8;
  localparam int Y_BITS     = 7;
  localparam int SCORE_BITS = 15;

  localparam logic [2:0] CELL_EMPTY = 3'd0;
  localparam logic [2:0] CELL_P1    = 3'd1;
  localparam logic [2:0] CELL_P2    = 3'd2;
  localparam logic [2:0] CELL_P3    = 3'd3;
  localparam logic [2:0] CELL_P4    = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } turf_state_t;

endpackage

// File: rtl/turf_addr_gen.sv
// Board x/y walker: y runs fastest and wraps into x. This block is shared with
// the move-writing engine so that both agree on the board traversal order.
module turf_addr_gen
  import turf_pkg::*;
#(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              last
);

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);

  logic [X_BITS-1:0] x_reg;
  logic [Y_BITS-1:0] y_reg;

  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (advance) begin
      if (y_reg == Y_MAX) begin
        y_reg <= '0;
        x_reg <= (x_reg == X_MAX) ? '0 : x_reg + 1'b1;
      end else begin
        y_reg <= y_reg + 1'b1;
      end
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign last = (x_reg == X_MAX) && (y_reg == Y_MAX);

endmodule

// File: rtl/turf_scorer.sv
// Full-board tally of cells owned by players 1..4, reading one cell per cycle.
// Define TURF_WINNER_EN to build the unique-maximum winner comparator.
module turf_scorer
  import turf_pkg::*;
#(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  output logic [14:0] address,
  input  logic [2:0]  q,
  output logic        busy,
  output logic        done,
  output logic [14:0] score1,
  output logic [14:0] score2,
  output logic [14:0] score3,
  output logic [14:0] score4,
  output logic [2:0]  winner
);

  turf_state_t state_reg, state_next;

  logic              valid_reg;
  logic              done_reg;
  logic              scan_start;
  logic              scan_last;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic [SCORE_BITS-1:0] score_arr [4];

  assign scan_start = (state_reg == IDLE) && start;

  turf_addr_gen #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_addr_gen (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (scan_start),
    .advance  (state_reg == SCAN),
    .x        (x),
    .y        (y),
    .last     (scan_last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      // q lags address by one cycle, so the sample enable lags SCAN by one too
      valid_reg <= (state_reg == SCAN);
      done_reg  <= (state_reg == DONE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (scan_last) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_score
      logic [SCORE_BITS-1:0] cnt_reg;

      always_ff @(posedge CLOCK_50) begin
        if (reset || scan_start) begin
          cnt_reg <= '0;
        end else if (valid_reg && (q == 3'(CELL_P1 + gi)) && (cnt_reg != {SCORE_BITS{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign score_arr[gi] = cnt_reg;
    end
  endgenerate

`ifdef TURF_WINNER_EN
  logic [2:0] winner_reg, winner_next;

  // Any tie at the maximum (including all-zero) yields no winner.
  always_comb begin
    logic [SCORE_BITS-1:0] best;
    logic                  tie;
    best        = '0;
    tie         = 1'b0;
    winner_next = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (score_arr[i] > best) begin
        best        = score_arr[i];
        winner_next = 3'(i + 1);
        tie         = 1'b0;
      end else if ((score_arr[i] == best) && (best != '0)) begin
        tie = 1'b1;
      end
    end
    if (tie) winner_next = 3'd0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || scan_start) begin
      winner_reg <= 3'd0;
    end else if (state_reg == DONE) begin
      winner_reg <= winner_next;
    end
  end

  assign winner = winner_reg;
`else
  assign winner = 3'd0;
`endif

  assign address = (state_reg == SCAN) ? {x, y} : 15'd0;
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign score1  = score_arr[0];
  assign score2  = score_arr[1];
  assign score3  = score_arr[2];
  assign score4  = score_arr[3];

endmodule
